data_store_buffer: RTL and testbench
====================================

# data_store_buffer

Data-side memory interface that sits directly downstream of the core's MEM stage, terminating the core data port (`data_address`, `data_bus`, `data_rw`, `data_cs`, `data_mode`). Stores are absorbed into a small FIFO in one cycle and drained to a slower external memory over a req/ack handshake. Loads wait for the FIFO to drain, then issue a single memory read and return the lane-extracted data on `data_bus`. A `data_wait` output is provided so the MEM stage can be held while a load or a full-buffer store is pending.

## Interface
- `DEPTH`, 4: store FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_address`  in  32  byte address from MEM.
- `data_bus`  inout  32  store data from the core; driven by this block only in the load-return cycle, otherwise high-Z.
- `data_rw`  in  1  1 = store, 0 = load.
- `data_cs`  in  1  access request valid.
- `data_mode`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `data_wait`  out  1  core must hold its request stable while this is high.
- `misalign_err`  out  1  one-cycle pulse when a misaligned access is dropped.
- `mem_req`  out  1  external memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address, bits [1:0] = 00.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  write data, with the store lane replicated across all byte positions.
- `mem_ack`  in  1  one-cycle completion strobe.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.

## Operation
- **Lane rules**
  - byte: `be = 0001 << addr[1:0]`; wdata = `{4{d[7:0]}}`.
  - half: `be = 0011 << addr[1:0]`; wdata = `{2{d[15:0]}}`.
  - word: `be = 1111`; wdata = `d`.
- **Load return**: the selected lane is right-justified and zero-extended. Sign extension is the MEM stage's responsibility.
- **Misalignment**: a half with `addr[0]=1`, or a word with `addr[1:0]!=0`, is not performed.
  - `misalign_err` pulses for one cycle.
  - `data_wait` stays low.
  - For a load, `data_bus` is driven with 0 in that cycle.
- **Store**: when `data_cs & data_rw` and the FIFO is not full (full is evaluated from the registered count), the entry {addr, be, wdata} is pushed at the edge and `data_wait` is low. When the FIFO is full, `data_wait` is high and nothing is pushed.
- **FSM states**: IDLE, WR, RD, RD_DONE.
  - **IDLE**
    - If the FIFO is non-empty → WR.
    - Otherwise, if a pending aligned load (`data_cs & !data_rw`) is present → RD. The load's addr and be are latched on this transition.
  - **WR**: `mem_req=1`, `mem_we=1`, and `mem_*` come from the FIFO head. On `mem_ack`, pop the FIFO → IDLE.
  - **RD**: `mem_req=1`, `mem_we=0`. On `mem_ack`, register the extracted lane → RD_DONE.
  - **RD_DONE**: drive `data_bus` with the registered data, `data_wait=0` → IDLE. The core consumes the load at this edge.
- **Load `data_wait`**: high from the first cycle of an aligned load until RD_DONE. Loads therefore never bypass buffered stores (no forwarding).
- **Simultaneous push and pop** in the same cycle: both happen and the count is unchanged.
- **`mem_*` hold**: outputs stay constant while `mem_req` is high and `mem_ack` is low.
- **Idle outputs**: `mem_req=0`, `mem_we=0`, and addr/be/wdata are 0.

## Timing
- **Store accept**: zero wait cycles when not full.
- **Minimum per store drain**: 2 cycles (IDLE → WR with an immediate ack).
- **Load latency** with an empty FIFO and an ack on the first `mem_req` cycle:
  - cycle 0: request seen, `data_wait=1`, IDLE → RD.
  - cycle 1: `mem_req`/`mem_ack` high.
  - cycle 2: RD_DONE, data on the bus, `data_wait=0`.
- **Load behind N buffered stores**: the stores drain first, then the 3-cycle load sequence runs.
- **`data_bus` drive**: only during RD_DONE or a misaligned-load cycle; never while `data_rw=1`.
- **Reset (`reset_n=0` at an edge)**: the reset state is reached at that edge; any in-flight memory transaction is abandoned.
  - State goes to IDLE and the FIFO empties (contents discarded).
  - `mem_req=0`, `data_wait=0`, `misalign_err=0`, `data_bus` high-Z.

## Test plan
- **Word store, empty FIFO**: word store to 0x100 with d=0xDEADBEEF and an immediate ack → `data_wait=0`. Next cycle `mem_req=1`, `mem_we=1`, addr 0x100, be 1111, wdata 0xDEADBEEF; after the ack the FIFO is empty.
- **Byte store**: byte store to 0x103 with d=0x000000A5 → be 1000, wdata 0xA5A5A5A5.
- **Half load**: memory returns 0x12345678 for a half load at 0x102 → `data_bus`=0x00001234 in RD_DONE, with `data_wait` high for exactly 2 cycles beforehand.
- **Store-buffer backpressure and ordering**: hold `mem_ack` low, then issue 5 stores.
  - The first 4 are accepted; the 5th sees `data_wait=1`.
  - Release the ack → the 5th is accepted after the first pop.
  - Memory sees all 5 writes in issue order.
- **Load behind stores**: 2 stores then a load to the same word → `mem_rdata` is requested only after both writes are acked. With a memory model, the load returns the stored value.
- **Misalignment and reset**: a word load at 0x101 → `misalign_err` pulses, no `mem_req`. Assert `reset_n=0` mid-RD → the next cycle shows `mem_req=0`, an empty FIFO, and `data_bus` high-Z.

Source files
------------

// File: rtl/data_store_buffer.sv
// data_store_buffer: terminates the core data port, absorbs stores into a
// small FIFO and drains them, or a single load, over a req/ack memory port.
module data_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_address,
    inout  wire  [31:0] data_bus,
    input  logic        data_rw,
    input  logic        data_cs,
    input  logic [1:0]  data_mode,
    output logic        data_wait,
    output logic        misalign_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [29:0]   fifo_addr  [DEPTH];
    logic [3:0]    fifo_be    [DEPTH];
    logic [31:0]   fifo_wdata [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [29:0] ld_addr;
    logic [3:0]  ld_be;
    logic [1:0]  ld_off;
    logic [1:0]  ld_mode;
    logic [31:0] ld_data;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        store_req;
    logic        load_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        ld_start;
    logic        ld_capture;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [15:0] rd_shift;
    logic [31:0] rd_lane;
    logic        bus_drive;
    logic [31:0] bus_out;

    assign is_byte = (data_mode == 2'b00);
    assign is_half = (data_mode == 2'b01);
    assign is_word = data_mode[1];

    assign misaligned = (is_half & data_address[0])
                      | (is_word & (|data_address[1:0]));

    assign store_req = data_cs & data_rw & ~misaligned;
    assign load_req  = data_cs & ~data_rw & ~misaligned;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    assign push = store_req & ~fifo_full;
    assign pop  = (state == WR) & mem_ack;

    assign ld_start   = (state == IDLE) & (state_nxt == RD);
    assign ld_capture = (state == RD) & mem_ack;

    // Byte enables and lane-replicated write data for the current request.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        unique case (1'b1)
            is_byte: begin
                lane_be    = 4'b0001 << data_address[1:0];
                lane_wdata = {4{data_bus[7:0]}};
            end
            is_half: begin
                lane_be    = 4'b0011 << data_address[1:0];
                lane_wdata = {2{data_bus[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = data_bus;
            end
        endcase
    end

    // Right-justify and zero-extend the loaded lane.
    assign rd_shift = 16'(mem_rdata >> {ld_off, 3'b000});

    always_comb begin
        rd_lane = mem_rdata;
        unique case (1'b1)
            ld_mode == 2'b00: rd_lane = {24'h0, rd_shift[7:0]};
            ld_mode == 2'b01: rd_lane = {16'h0, rd_shift};
            default:          rd_lane = mem_rdata;
        endcase
    end

    // Store FIFO storage; contents need no reset, pointers guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= data_address[31:2];
            fifo_be[wr_ptr]    <= lane_be;
            fifo_wdata[wr_ptr] <= lane_wdata;
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: drain stores first, a load only starts on an empty FIFO.
    // A store being pushed this cycle already counts as buffered work.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty || push) begin
                    state_nxt = WR;
                end else if (load_req) begin
                    state_nxt = RD;
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory port outputs; held stable by the state and the FIFO head.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        unique case (state)
            WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {fifo_addr[rd_ptr], 2'b00};
                mem_be    = fifo_be[rd_ptr];
                mem_wdata = fifo_wdata[rd_ptr];
            end
            RD: begin
                mem_req  = 1'b1;
                mem_addr = {ld_addr, 2'b00};
                mem_be   = ld_be;
            end
            default: begin
            end
        endcase
    end

    // Latch the load request as the read is launched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_addr <= '0;
            ld_be   <= '0;
            ld_off  <= '0;
            ld_mode <= '0;
        end else if (ld_start) begin
            ld_addr <= data_address[31:2];
            ld_be   <= lane_be;
            ld_off  <= data_address[1:0];
            ld_mode <= data_mode;
        end
    end

    // Capture the extracted lane when the read completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_data <= '0;
        end else if (ld_capture) begin
            ld_data <= rd_lane;
        end
    end

    // Core handshake: hold for a full buffer or any load not yet returned.
    assign data_wait = (store_req & fifo_full)
                     | (load_req & (state != RD_DONE));

    assign misalign_err = data_cs & misaligned;

    // The bus is only driven for a load return or a dropped load.
    assign bus_drive = ~data_rw
                     & ((state == RD_DONE) | (data_cs & misaligned));
    assign bus_out   = (state == RD_DONE) ? ld_data : 32'h0;
    assign data_bus  = bus_drive ? bus_out : 32'hz;

endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: vector table, directed corner sequences and a
// randomized run against a byte-level memory reference model.
module tb_data_store_buffer;

    logic        clk;
    logic        reset_n;
    logic [31:0] data_address;
    wire  [31:0] data_bus;
    logic        data_rw;
    logic        data_cs;
    logic [1:0]  data_mode;
    logic        data_wait;
    logic        misalign_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        core_drive;
    logic [31:0] core_d;

    assign data_bus = core_drive ? core_d : 32'hz;

    data_store_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_address (data_address),
        .data_bus     (data_bus),
        .data_rw      (data_rw),
        .data_cs      (data_cs),
        .data_mode    (data_mode),
        .data_wait    (data_wait),
        .misalign_err (misalign_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        rw;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] val;
    } vec_t;

    int checks;
    int errors;
    int ack_mode;

    logic [31:0] dev_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    wr_t         wlog[$];
    wr_t         expq[$];
    vec_t        vt[12];

    logic        s_wait;
    logic        s_err;
    logic        s_req;
    logic        s_we;
    logic        s_ack;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic [31:0] s_bus;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a,
                                            input bit from_ref);
        int unsigned k;
        k = a >> 2;
        if (from_ref) return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        return dev_mem.exists(k) ? dev_mem[k] : 32'h0;
    endfunction

    task automatic dev_write(input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        logic [31:0] w;
        w = word_of(a, 1'b0);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        dev_mem[a >> 2] = w;
    endtask

    function automatic int nbytes(input logic [1:0] m);
        if (m == 2'b00) return 1;
        if (m == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [1:0] m,
                                       input logic [31:0] a);
        return (a % nbytes(m)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] m,
                                            input logic [31:0] a);
        logic [3:0] be;
        int off;
        be = 4'b0000;
        off = a % 4;
        for (int k = 0; k < nbytes(m); k++)
            if (off + k < 4) be[off + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] m,
                                             input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(m);
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = d[8*(k % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] m,
                                             input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int off;
        w = word_of(a, 1'b1);
        v = 32'h0;
        off = a % 4;
        for (int k = 0; k < nbytes(m); k++)
            v[8*k +: 8] = w[8*(off + k) +: 8];
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        logic [31:0] w;
        w = word_of(a, 1'b1);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a >> 2] = w;
    endtask

    task automatic drive(input logic rw, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] d);
        data_cs      = 1'b1;
        data_rw      = rw;
        data_mode    = m;
        data_address = a;
        core_d       = d;
        core_drive   = rw;
    endtask

    task automatic idle_core();
        data_cs      = 1'b0;
        data_rw      = 1'b0;
        data_mode    = 2'b00;
        data_address = 32'h0;
        core_drive   = 1'b0;
    endtask

    // One clock: memory answers mid-cycle, outputs are snapshotted
    // before the rising edge, writes are logged as they are acked.
    task automatic cycle();
        #3;
        if (mem_req) begin
            if (ack_mode == 1) mem_ack = 1'b1;
            else if (ack_mode == 2) mem_ack = ($urandom_range(0, 1) == 1);
            else mem_ack = 1'b0;
        end else begin
            mem_ack = 1'b0;
        end
        if (mem_req && !mem_we) mem_rdata = word_of(mem_addr, 1'b0);
        else mem_rdata = $urandom();
        #1;
        s_wait  = data_wait;
        s_err   = misalign_err;
        s_req   = mem_req;
        s_we    = mem_we;
        s_ack   = mem_ack;
        s_addr  = mem_addr;
        s_be    = mem_be;
        s_wdata = mem_wdata;
        s_bus   = data_bus;
        if (mem_ack && mem_we && reset_n) begin
            wlog.push_back('{mem_addr, mem_be, mem_wdata});
            dev_write(mem_addr, mem_be, mem_wdata);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    int  n;
    bit  rd_seen;
    logic        r_rw;
    logic [1:0]  r_m;
    logic [31:0] r_a;
    logic [31:0] r_d;
    logic        r_mis;

    initial begin
        checks   = 0;
        errors   = 0;
        ack_mode = 1;
        reset_n  = 1'b0;
        mem_ack  = 1'b0;
        mem_rdata = 32'h0;
        core_d   = 32'h0;
        idle_core();

        vt[0]  = '{1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vt[1]  = '{1'b1, 2'b00, 32'h103, 32'h000000A5, 4'h8, 32'hA5A5A5A5};
        vt[2]  = '{1'b1, 2'b00, 32'h101, 32'h12345677, 4'h2, 32'h77777777};
        vt[3]  = '{1'b1, 2'b01, 32'h102, 32'hCAFEBABE, 4'hC, 32'hBABEBABE};
        vt[4]  = '{1'b1, 2'b01, 32'h200, 32'h00001357, 4'h3, 32'h13571357};
        vt[5]  = '{1'b1, 2'b11, 32'h204, 32'h0BADF00D, 4'hF, 32'h0BADF00D};
        vt[6]  = '{1'b0, 2'b01, 32'h102, 32'h12345678, 4'hC, 32'h00001234};
        vt[7]  = '{1'b0, 2'b00, 32'h301, 32'h89ABCDEF, 4'h2, 32'h000000CD};
        vt[8]  = '{1'b0, 2'b00, 32'h303, 32'h89ABCDEF, 4'h8, 32'h00000089};
        vt[9]  = '{1'b0, 2'b01, 32'h300, 32'h89ABCDEF, 4'h3, 32'h0000CDEF};
        vt[10] = '{1'b0, 2'b10, 32'h304, 32'hFEEDFACE, 4'hF, 32'hFEEDFACE};
        vt[11] = '{1'b0, 2'b11, 32'h308, 32'h01020304, 4'hF, 32'h01020304};

        // Reset state, with the bench probing the bus for a second driver.
        core_drive = 1'b1;
        core_d     = 32'h5A5AC3C3;
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("rst_req", s_req, 0);
        chk("rst_wait", s_wait, 0);
        chk("rst_err", s_err, 0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_be", s_be, 0);
        chk("rst_wdata", s_wdata, 32'h0);
        chk("rst_bus_hiz", s_bus, 32'h5A5AC3C3);
        idle_core();
        cycle();

        // Single transactions on an empty FIFO with immediate acks.
        ack_mode = 1;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].rw) begin
                drive(1'b1, vt[i].mode, vt[i].addr, vt[i].d);
                cycle();
                chk("vec_st_wait", s_wait, 0);
                chk("vec_st_req0", s_req, 0);
                idle_core();
                cycle();
                chk("vec_st_req", s_req, 1);
                chk("vec_st_we", s_we, 1);
                chk("vec_st_addr", s_addr, vt[i].addr & 32'hFFFFFFFC);
                chk("vec_st_be", s_be, vt[i].be);
                chk("vec_st_wdata", s_wdata, vt[i].val);
                cycle();
                chk("vec_st_empty", s_req, 0);
            end else begin
                dev_mem[vt[i].addr >> 2] = vt[i].d;
                drive(1'b0, vt[i].mode, vt[i].addr, 32'h0);
                cycle();
                chk("vec_ld_wait0", s_wait, 1);
                chk("vec_ld_req0", s_req, 0);
                cycle();
                chk("vec_ld_wait1", s_wait, 1);
                chk("vec_ld_req1", s_req, 1);
                chk("vec_ld_we", s_we, 0);
                chk("vec_ld_addr", s_addr, vt[i].addr & 32'hFFFFFFFC);
                chk("vec_ld_be", s_be, vt[i].be);
                cycle();
                chk("vec_ld_wait2", s_wait, 0);
                chk("vec_ld_data", s_bus, vt[i].val);
                idle_core();
                cycle();
            end
        end

        // Backpressure: four stores fill the FIFO, the fifth waits.
        ack_mode = 0;
        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, 32'h400 + 4 * i, 32'hA0000000 + i);
            cycle();
            if (i < 4) chk("bp_accept", s_wait, 0);
            else chk("bp_full", s_wait, 1);
        end
        cycle();
        chk("bp_full_hold", s_wait, 1);
        chk("bp_head_addr", s_addr, 32'h400);
        ack_mode = 1;
        cycle();
        chk("bp_pop_wait", s_wait, 1);
        chk("bp_pop_ack", s_ack, 1);
        cycle();
        chk("bp_accept5", s_wait, 0);
        idle_core();
        n = 0;
        while (wlog.size() < 5 && n < 40) begin
            cycle();
            n++;
        end
        chk("bp_wcount", wlog.size(), 5);
        for (int i = 0; i < wlog.size() && i < 5; i++) begin
            chk("bp_order_addr", wlog[i].addr, 32'h400 + 4 * i);
            chk("bp_order_data", wlog[i].data, 32'hA0000000 + i);
        end

        // Load behind two stores to the same word.
        wlog.delete();
        drive(1'b1, 2'b10, 32'h500, 32'h11111111);
        cycle();
        chk("lb_st0", s_wait, 0);
        drive(1'b1, 2'b00, 32'h501, 32'h00000022);
        cycle();
        chk("lb_st1", s_wait, 0);
        drive(1'b0, 2'b10, 32'h500, 32'h0);
        rd_seen = 1'b0;
        n = 0;
        do begin
            cycle();
            if (s_req && !s_we && !rd_seen) begin
                rd_seen = 1'b1;
                chk("lb_order", wlog.size(), 2);
            end
            n++;
        end while (s_wait && n < 40);
        chk("lb_rd_seen", rd_seen, 1);
        chk("lb_wait", s_wait, 0);
        chk("lb_data", s_bus, 32'h11112211);
        idle_core();
        cycle();

        // Misaligned load and store are dropped with a pulse.
        drive(1'b0, 2'b10, 32'h101, 32'h0);
        cycle();
        chk("mis_ld_err", s_err, 1);
        chk("mis_ld_wait", s_wait, 0);
        chk("mis_ld_req", s_req, 0);
        chk("mis_ld_bus", s_bus, 32'h0);
        idle_core();
        cycle();
        chk("mis_err_clr", s_err, 0);
        chk("mis_ld_noreq", s_req, 0);
        drive(1'b1, 2'b01, 32'h203, 32'h00005555);
        cycle();
        chk("mis_st_err", s_err, 1);
        chk("mis_st_wait", s_wait, 0);
        idle_core();
        cycle();
        cycle();
        chk("mis_st_noreq", s_req, 0);

        // Reset in the middle of a read.
        ack_mode = 0;
        drive(1'b0, 2'b10, 32'h600, 32'h0);
        cycle();
        cycle();
        chk("rrd_req", s_req, 1);
        chk("rrd_we", s_we, 0);
        idle_core();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        core_drive = 1'b1;
        core_d = 32'h5A5AC3C3;
        cycle();
        chk("rrd_req_off", s_req, 0);
        chk("rrd_wait", s_wait, 0);
        chk("rrd_err", s_err, 0);
        chk("rrd_bus_hiz", s_bus, 32'h5A5AC3C3);
        idle_core();

        // Reset with stores buffered discards them.
        wlog.delete();
        drive(1'b1, 2'b10, 32'h700, 32'h77777777);
        cycle();
        drive(1'b1, 2'b10, 32'h704, 32'h88888888);
        cycle();
        chk("rst_fifo_st", s_wait, 0);
        idle_core();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        ack_mode = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_fifo_empty", s_req, 0);
        end
        chk("rst_fifo_nowr", wlog.size(), 0);

        // Randomized traffic against the reference model.
        ack_mode = 2;
        wlog.delete();
        expq.delete();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_core();
                cycle();
                continue;
            end
            r_rw = 1'($urandom_range(0, 1));
            r_m  = 2'($urandom_range(0, 3));
            r_a  = 32'h800 + $urandom_range(0, 31);
            r_d  = $urandom();
            r_mis = model_mis(r_m, r_a);
            drive(r_rw, r_m, r_a, r_d);
            n = 0;
            do begin
                cycle();
                n++;
            end while (s_wait && n < 100);
            chk("rnd_wait", s_wait, 0);
            chk("rnd_err", s_err, r_mis);
            if (!r_mis && r_rw) begin
                expq.push_back('{r_a & 32'hFFFFFFFC, model_be(r_m, r_a),
                                 model_wd(r_m, r_d)});
                ref_write(r_a, model_be(r_m, r_a), model_wd(r_m, r_d));
            end else if (!r_mis) begin
                chk("rnd_load", s_bus, model_ld(r_m, r_a));
            end else if (!r_rw) begin
                chk("rnd_mis_bus", s_bus, 32'h0);
            end
        end
        idle_core();
        n = 0;
        while (wlog.size() < expq.size() && n < 200) begin
            cycle();
            n++;
        end
        chk("rnd_wcount", wlog.size(), expq.size());
        for (int i = 0; i < wlog.size() && i < expq.size(); i++) begin
            chk("rnd_w_addr", wlog[i].addr, expq[i].addr);
            chk("rnd_w_be", {28'h0, wlog[i].be}, {28'h0, expq[i].be});
            chk("rnd_w_data", wlog[i].data, expq[i].data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
